// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
//   INST_NOP     : instruction word returned whenever no valid, good response is present
//   imr_state_e  : responder FSM state encoding
//   addr_is_bad  : flags a fetch address that is misaligned or beyond the memory size
package inst_mem_responder_pkg;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IMR_IDLE = 2'd0,
      IMR_WAIT = 2'd1,
      IMR_RESP = 2'd2
   } imr_state_e;

   // True when the byte address is not word aligned or selects a word past
   // the end of a 2^depth_log2-word memory.
   function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned depth_log2);
      return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 32'd2)) != 32'd0);
   endfunction

endpackage

// File: rtl/inst_ram_array.sv
// Instruction storage: 2^DEPTH_LOG2 x 32-bit words.
//   clk     : clock
//   wr_en   : write strobe (already range-qualified by the caller)
//   wr_idx  : word index to write
//   wr_data : word to write
//   rd_en   : capture mem[rd_idx] into rd_data on this edge
//   rd_idx  : word index to read
//   rd_data : registered read data, held until the next rd_en
// A read and a write to the same word on the same edge return the old word.
module inst_ram_array #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [31:0]           wr_data,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [31:0]           rd_data
);

   logic [31:0] mem_reg [2**DEPTH_LOG2];
   logic [31:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_data_reg <= mem_reg[rd_idx];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the fetch interface. Grants word fetches
// with a request/grant handshake and returns the addressed word WAIT_CYCLES+1
// cycles after the grant. The response is held while hold_i is high and any
// in-flight or pending fetch is dropped on flush_i.
//   clk, rst          : clock and synchronous active-high reset
//   req_i, addr_i     : fetch request and byte address
//   gnt_o             : request accepted this cycle (combinational)
//   rvalid_o          : response valid
//   rdata_o           : instruction word, INST_NOP when invalid or erroneous
//   raddr_o           : byte address of the current response
//   err_o             : response address misaligned or out of range (qualified by rvalid_o)
//   flush_i           : jump taken, discard in-flight fetch
//   hold_i            : consumer stalled, keep current response
//   wr_en_i, wr_addr_i, wr_data_i : program-load write port
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2  = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] raddr_o,
   output logic        err_o,
   input  logic        flush_i,
   input  logic        hold_i,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i
);

   localparam logic [3:0] WAIT_LOAD    = 4'(WAIT_CYCLES);
   localparam imr_state_e GRANT_TARGET = (WAIT_CYCLES == 0) ? IMR_RESP : IMR_WAIT;

   imr_state_e  state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] raddr_reg;
   logic        err_reg;

   logic        resp_load;    // a new response is being latched on this edge
   logic [31:0] fetch_addr;   // address of the response being latched
   logic [31:0] ram_rdata;
   logic        wr_ok;

   // Low address bits are ignored for writes; only the word range matters.
   assign wr_ok = wr_en_i && !addr_is_bad(wr_addr_i & 32'hFFFF_FFFC, DEPTH_LOG2);

   assign gnt_o = req_i && !flush_i &&
                  ((state_reg == IMR_IDLE) || ((state_reg == IMR_RESP) && !hold_i));

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      resp_load  = 1'b0;
      fetch_addr = addr_reg;

      case (state_reg)
         IMR_IDLE: begin
            state_next = IMR_IDLE;
         end
         IMR_WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = IMR_RESP;
               resp_load  = 1'b1;
            end
         end
         IMR_RESP: begin
            // Consumed unless stalled; a back-to-back grant overrides below.
            if (!hold_i) begin
               state_next = IMR_IDLE;
            end
         end
         default: begin
            state_next = IMR_IDLE;
         end
      endcase

      if (gnt_o) begin
         state_next = GRANT_TARGET;
         cnt_next   = WAIT_LOAD;
         addr_next  = addr_i;
         // With no wait states the granted address goes straight to the RAM.
         if (WAIT_CYCLES == 0) begin
            resp_load  = 1'b1;
            fetch_addr = addr_i;
         end
      end

      // Flush beats hold and any pending entry into RESP.
      if (flush_i) begin
         state_next = IMR_IDLE;
         cnt_next   = 4'd0;
         resp_load  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IMR_IDLE;
         cnt_reg   <= 4'd0;
         addr_reg  <= 32'd0;
         raddr_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         if (resp_load) begin
            raddr_reg <= fetch_addr;
            err_reg   <= addr_is_bad(fetch_addr, DEPTH_LOG2);
         end
      end
   end

   inst_ram_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_idx  (wr_addr_i[DEPTH_LOG2+1:2]),
      .wr_data (wr_data_i),
      .rd_en   (resp_load),
      .rd_idx  (fetch_addr[DEPTH_LOG2+1:2]),
      .rd_data (ram_rdata)
   );

   // rdata_o is selected between registered RAM data and the NOP constant
   // using registered state only, so it carries no combinational input path.
   assign rvalid_o = (state_reg == IMR_RESP);
   assign err_o    = err_reg;
   assign raddr_o  = raddr_reg;
   assign rdata_o  = (rvalid_o && !err_reg) ? ram_rdata : INST_NOP;

endmodule
